// File: rtl/bimodal_predictor_pkg.sv
// Shared encodings and counter-init helpers for the bimodal branch predictor.
package bimodal_predictor_pkg;

  localparam int MODE_ALWAYS  = 0;
  localparam int MODE_COUNTER = 1;

  function automatic int unsigned ctr_weak_taken(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  function automatic int unsigned ctr_weak_not_taken(input int unsigned bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction

  function automatic int unsigned ctr_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/bimodal_predictor_table.sv
// Direct-mapped valid/tag/target/counter storage: two async read ports, one sync write port.
module predictor_table
  import bimodal_predictor_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 8,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [WORD_SIZE-1:0]  rd_target,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic [INDEX_BITS-1:0] up_idx,
  output logic                  up_valid,
  output logic [TAG_BITS-1:0]   up_tag,
  output logic [WORD_SIZE-1:0]  up_target,
  output logic [CTR_BITS-1:0]   up_ctr,
  input  logic                  wr_en,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [WORD_SIZE-1:0]  wr_target,
  input  logic [CTR_BITS-1:0]   wr_ctr
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));

  logic [DEPTH-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q    [DEPTH];
  logic [WORD_SIZE-1:0] target_q [DEPTH];
  logic [CTR_BITS-1:0]  ctr_q    [DEPTH];

  // Reset beats clear, clear beats any write.
  logic wr_ok;
  assign wr_ok = reset_n && !clear && wr_en;

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];

  assign up_valid  = valid_q[up_idx];
  assign up_tag    = tag_q[up_idx];
  assign up_target = target_q[up_idx];
  assign up_ctr    = ctr_q[up_idx];

  always_ff @(posedge clk) begin
    if (!reset_n)   valid_q <= '0;
    else if (clear) valid_q <= '0;
    else if (wr_en) valid_q[up_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (wr_ok) begin
      ctr_q[up_idx] <= wr_ctr;
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      tag_q[up_idx]    <= wr_tag;
      target_q[up_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/bimodal_predictor.sv
// Bimodal branch predictor: zero-latency lookup, counter/target update policy, mispredict stats.
module bimodal_predictor
  import bimodal_predictor_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 8,
  parameter int CTR_BITS   = 2,
  parameter int MODE       = MODE_COUNTER
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] read_pc,
  output logic                 predict_hit,
  output logic                 predict_taken,
  output logic [WORD_SIZE-1:0] predict_target,
  input  logic                 update_valid,
  input  logic [WORD_SIZE-1:0] update_pc,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 update_taken,
  input  logic                 update_is_jump,
  input  logic                 update_mispredict,
  input  logic                 clear,
  output logic [WORD_SIZE-1:0] stat_mispredict
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_taken(CTR_BITS));

  logic [INDEX_BITS-1:0] rd_idx, up_idx;
  logic [TAG_BITS-1:0]   rd_key, up_key;
  logic                  rd_valid, up_valid;
  logic [TAG_BITS-1:0]   rd_tag, up_tag;
  logic [WORD_SIZE-1:0]  rd_target, up_target;
  logic [CTR_BITS-1:0]   rd_ctr, up_ctr;
  logic                  up_hit, wr_en;
  logic [WORD_SIZE-1:0]  wr_target;
  logic [CTR_BITS-1:0]   wr_ctr;

  assign rd_idx = read_pc[INDEX_BITS-1:0];
  assign rd_key = read_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign up_idx = update_pc[INDEX_BITS-1:0];
  assign up_key = update_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];

  predictor_table #(
    .WORD_SIZE (WORD_SIZE),
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS),
    .CTR_BITS  (CTR_BITS)
  ) u_table (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_target(rd_target),
    .rd_ctr   (rd_ctr),
    .up_idx   (up_idx),
    .up_valid (up_valid),
    .up_tag   (up_tag),
    .up_target(up_target),
    .up_ctr   (up_ctr),
    .wr_en    (wr_en),
    .wr_tag   (up_key),
    .wr_target(wr_target),
    .wr_ctr   (wr_ctr)
  );

  // Lookup sees only pre-edge state; a same-cycle update is never bypassed.
  assign predict_hit    = rd_valid && (rd_tag == rd_key);
  assign predict_taken  = predict_hit && (MODE == MODE_ALWAYS || rd_ctr[CTR_BITS-1]);
  assign predict_target = predict_taken ? rd_target : read_pc + WORD_SIZE'(1);

  assign up_hit = up_valid && (up_tag == up_key);

  always_comb begin
    wr_en     = 1'b0;
    wr_ctr    = up_ctr;
    wr_target = up_target;
    if (update_valid) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (update_is_jump)    wr_ctr = CTR_MAX;
        else if (update_taken) wr_ctr = (up_ctr == CTR_MAX) ? up_ctr : up_ctr + CTR_BITS'(1);
        else                   wr_ctr = (up_ctr == '0) ? up_ctr : up_ctr - CTR_BITS'(1);
        if (update_taken) wr_target = update_target;
      end else if (update_taken) begin
        // Miss allocation evicts whatever lives at this index.
        wr_en     = 1'b1;
        wr_ctr    = update_is_jump ? CTR_MAX : CTR_WT;
        wr_target = update_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      stat_mispredict <= '0;
    else if (update_valid && update_mispredict && stat_mispredict != '1)
      stat_mispredict <= stat_mispredict + WORD_SIZE'(1);
  end

endmodule
